// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: PC register, redirect selection (jr > j/jal > branch)
// and the IF/ID pipeline register with a count of delivered instructions.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Br_Taken,
  input  logic [15:0] Br_Offset,
  input  logic        Jmp_Taken,
  input  logic [25:0] Jmp_Index,
  input  logic        Jr_Taken,
  input  logic [31:0] Jr_Addr,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  output logic [31:0] ID_Inst,
  output logic [31:0] ID_PC4,
  output logic        ID_Valid,
  output logic [31:0] Fetch_Count
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [31:0] idInst_q, idInst_d;
  logic [31:0] idPc4_q, idPc4_d;
  logic        idValid_q, idValid_d;
  logic [31:0] fetchCount_q, fetchCount_d;

  logic [31:0] pcPlus4;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] jrTarget;
  logic [31:0] redirectTarget;
  logic        redirect;

  assign pcPlus4      = pc_q + 32'd4;
  assign branchTarget = idPc4_q + {{14{Br_Offset[15]}}, Br_Offset, 2'b00};
  assign jumpTarget   = {idPc4_q[31:28], Jmp_Index, 2'b00};
  assign jrTarget     = Jr_Addr & 32'hFFFF_FFFC;

  // Control transfers are only trusted when the instruction in ID is real
  // and decode is not holding it.
  always_comb begin
    redirect       = idValid_q && !Stall && (Jr_Taken || Jmp_Taken || Br_Taken);
    redirectTarget = branchTarget;
    if (Jr_Taken) begin
      redirectTarget = jrTarget;
    end else if (Jmp_Taken) begin
      redirectTarget = jumpTarget;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    idInst_d     = idInst_q;
    idPc4_d      = idPc4_q;
    idValid_d    = idValid_q;
    fetchCount_d = fetchCount_q;
    if (!Stall) begin
      if (redirect || Flush) begin
        pc_d      = redirect ? redirectTarget : pcPlus4;
        idInst_d  = 32'h0;
        idPc4_d   = 32'h0;
        idValid_d = 1'b0;
      end else begin
        pc_d         = pcPlus4;
        idInst_d     = Imem_Data;
        idPc4_d      = pcPlus4;
        idValid_d    = 1'b1;
        fetchCount_d = fetchCount_q + 32'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q         <= ResetPcAligned;
      idInst_q     <= 32'h0;
      idPc4_q      <= 32'h0;
      idValid_q    <= 1'b0;
      fetchCount_q <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      idInst_q     <= idInst_d;
      idPc4_q      <= idPc4_d;
      idValid_q    <= idValid_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  assign Imem_Addr   = pc_q;
  assign ID_Inst     = idInst_q;
  assign ID_PC4      = idPc4_q;
  assign ID_Valid    = idValid_q;
  assign Fetch_Count = fetchCount_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed scenarios followed by random traffic,
// all compared against a behavioural model of the fetch stage.
module tb_inst_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        Br_Taken;
  logic [15:0] Br_Offset;
  logic        Jmp_Taken;
  logic [25:0] Jmp_Index;
  logic        Jr_Taken;
  logic [31:0] Jr_Addr;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Data;
  logic [31:0] ID_Inst;
  logic [31:0] ID_PC4;
  logic        ID_Valid;
  logic [31:0] Fetch_Count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mPc, mInst, mPc4, mCount;
  logic        mValid;
  logic [31:0] savedPc, savedPc4, savedCount;

  inst_fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .Br_Taken(Br_Taken), .Br_Offset(Br_Offset),
    .Jmp_Taken(Jmp_Taken), .Jmp_Index(Jmp_Index),
    .Jr_Taken(Jr_Taken), .Jr_Addr(Jr_Addr),
    .Imem_Addr(Imem_Addr), .Imem_Data(Imem_Data),
    .ID_Inst(ID_Inst), .ID_PC4(ID_PC4), .ID_Valid(ID_Valid),
    .Fetch_Count(Fetch_Count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Address-dependent instruction memory so misrouted fetches show up in ID_Inst.
  function automatic logic [31:0] imemWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h1234_5678;
  endfunction

  assign Imem_Data = imemWord(Imem_Addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("imem_addr", Imem_Addr, mPc);
    checkOutput("id_inst", ID_Inst, mInst);
    checkOutput("id_pc4", ID_PC4, mPc4);
    checkOutput("id_valid", {31'b0, ID_Valid}, {31'b0, mValid});
    checkOutput("fetch_count", Fetch_Count, mCount);
  endtask

  task automatic modelReset();
    mPc = 32'h0; mInst = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mCount = 32'h0;
  endtask

  // One clock of the reference model, written from the stage's rules.
  task automatic modelClock(input bit stall, input bit flush, input bit br,
                            input logic [15:0] off, input bit jmp,
                            input logic [25:0] idx, input bit jr,
                            input logic [31:0] jrAddr);
    int signed byteOffset;
    logic [31:0] target;
    bit taken;
    if (stall) return;
    byteOffset = $signed(off);
    byteOffset = byteOffset * 4;
    taken = mValid && (jr || jmp || br);
    if (jr)       target = jrAddr - (jrAddr % 4);
    else if (jmp) target = (mPc4 & 32'hF000_0000) + {6'b0, idx} * 4;
    else          target = mPc4 + 32'(byteOffset);
    if (taken || flush) begin
      mPc = taken ? target : mPc + 4;
      mInst = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
    end else begin
      mInst = imemWord(mPc);
      mPc4 = mPc + 4;
      mValid = 1'b1;
      mCount = mCount + 1;
      mPc = mPc + 4;
    end
  endtask

  task automatic applyStimulus(input bit stall, input bit flush, input bit br,
                               input logic [15:0] off, input bit jmp,
                               input logic [25:0] idx, input bit jr,
                               input logic [31:0] jrAddr);
    Stall = stall; Flush = flush; Br_Taken = br; Br_Offset = off;
    Jmp_Taken = jmp; Jmp_Index = idx; Jr_Taken = jr; Jr_Addr = jrAddr;
    modelClock(stall, flush, br, off, jmp, idx, jr, jrAddr);
    @(posedge Clk);
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic jumpReg(input logic [31:0] addr);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, addr);
  endtask

  // Asynchronous reset between edges, held across one edge with noisy inputs.
  task automatic resetPulse();
    #2;
    Reset = 1'b0;
    Stall = 1'b1; Br_Taken = 1'b1; Jr_Taken = 1'b1; Jr_Addr = 32'h0000_0800;
    modelReset();
    #1;
    checkAll();
    @(posedge Clk);
    #1;
    checkAll();
    Reset = 1'b1;
    Stall = 1'b0; Br_Taken = 1'b0; Jr_Taken = 1'b0; Jr_Addr = 32'h0;
    #2;
  endtask

  initial begin
    Reset = 1'b0;
    Stall = 1'b0; Flush = 1'b0; Br_Taken = 1'b0; Br_Offset = 16'h0;
    Jmp_Taken = 1'b0; Jmp_Index = 26'h0; Jr_Taken = 1'b0; Jr_Addr = 32'h0;
    modelReset();
    #12;
    checkAll();
    Reset = 1'b1;

    // Sequential fetch from the reset address.
    idle();
    checkOutput("seq_addr1", Imem_Addr, 32'h4);
    checkOutput("seq_pc4_1", ID_PC4, 32'h4);
    idle();
    checkOutput("seq_addr2", Imem_Addr, 32'h8);
    checkOutput("seq_pc4_2", ID_PC4, 32'h8);
    idle();
    checkOutput("seq_addr3", Imem_Addr, 32'hC);
    checkOutput("seq_pc4_3", ID_PC4, 32'hC);
    checkOutput("seq_count", Fetch_Count, 32'd3);
    idle();

    // Backward branch from ID_PC4 = 0x10.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("br_pc", Imem_Addr, 32'h8);
    checkOutput("br_valid", {31'b0, ID_Valid}, 32'h0);
    checkOutput("br_count", Fetch_Count, 32'd4);

    // Jr beats jump; then jump alone.
    idle();
    jumpReg(32'h4000_000C);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 26'h10, 1'b1, 32'h123);
    checkOutput("prio_jr", Imem_Addr, 32'h120);
    idle();
    jumpReg(32'h4000_000C);
    idle();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 26'h10, 1'b0, 32'h123);
    checkOutput("prio_jmp", Imem_Addr, 32'h4000_0040);

    // Stall freezes everything, including a pending branch and flush.
    idle();
    savedPc = Imem_Addr; savedPc4 = ID_PC4; savedCount = Fetch_Count;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("stall_pc", Imem_Addr, savedPc);
    checkOutput("stall_pc4", ID_PC4, savedPc4);
    checkOutput("stall_count", Fetch_Count, savedCount);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("stall_release_br", Imem_Addr, savedPc4 + 32'd16);

    // Flush without redirect advances the PC and bubbles ID.
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);

    // PC wraps from the top of the address space.
    idle();
    jumpReg(32'hFFFF_FFFF);
    checkOutput("jr_lowbits", Imem_Addr, 32'hFFFF_FFFC);
    idle();
    checkOutput("wrap_pc", Imem_Addr, 32'h0);
    checkOutput("wrap_pc4", ID_PC4, 32'h0);
    checkOutput("wrap_valid", {31'b0, ID_Valid}, 32'h1);

    // Asynchronous reset with PC at 0x40, then restart from the reset address.
    jumpReg(32'h0000_003C);
    idle();
    checkOutput("pre_reset_pc", Imem_Addr, 32'h40);
    resetPulse();
    checkOutput("async_pc", Imem_Addr, 32'h0);
    checkOutput("async_valid", {31'b0, ID_Valid}, 32'h0);
    idle();
    checkOutput("restart_pc4", ID_PC4, 32'h4);
    checkOutput("restart_inst", ID_Inst, imemWord(32'h0));

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        resetPulse();
      end else begin
        applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                      $urandom_range(0, 3) == 0, 16'($urandom),
                      $urandom_range(0, 6) == 0, 26'($urandom),
                      $urandom_range(0, 9) == 0, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
INST_FETCH_STAGE -- requirements
Module: inst_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port Clk  input  1  single clock, all state updates on posedge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Stall  input  1  hazard hold from decode stage.
REQ-005 SHALL have port Flush  input  1  squash IF/ID contents.
REQ-006 SHALL have port Br_Taken  input  1  conditional branch (beq/bne) resolved taken in ID.
REQ-007 SHALL have port Br_Offset  input  16  branch immediate from ID instruction.
REQ-008 SHALL have port Jmp_Taken  input  1  j/jal in ID.
REQ-009 SHALL have port Jmp_Index  input  26  jump index from ID instruction.
REQ-010 SHALL have port Jr_Taken  input  1  jr in ID.
REQ-011 SHALL have port Jr_Addr  input  32  register target for jr.
REQ-012 SHALL have port Imem_Addr  output  32  instruction memory address, equals current PC.
REQ-013 SHALL have port Imem_Data  input  32  instruction word, combinational same-cycle read.
REQ-014 SHALL have port ID_Inst  output  32  IF/ID instruction register.
REQ-015 SHALL have port ID_PC4  output  32  IF/ID PC+4 of held instruction.
REQ-016 SHALL have port ID_Valid  output  1  IF/ID holds real instruction (0 = bubble).
REQ-017 SHALL have port Fetch_Count  output  32  number of valid instructions delivered to ID.

Function
REQ-018 SHALL hold PC register; Imem_Addr = PC combinationally; PC[1:0] always 2'b00.
REQ-019 Redirect SHALL be honoured only when ID_Valid=1 and Stall=0; otherwise Br_Taken/Jmp_Taken/Jr_Taken ignored.
REQ-020 Redirect priority SHALL be Jr_Taken > Jmp_Taken > Br_Taken.
REQ-021 Branch target SHALL be ID_PC4 + (sign-extended Br_Offset << 2), 32-bit modulo arithmetic, carry discarded.
REQ-022 Jump target SHALL be {ID_PC4[31:28], Jmp_Index, 2'b00}.
REQ-023 Jr target SHALL be {Jr_Addr[31:2], 2'b00}; low bits silently ignored.
REQ-024 Next PC when Stall=0, no redirect: PC+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-025 Stall=1 SHALL hold PC, ID_Inst, ID_PC4, ID_Valid, Fetch_Count unchanged; Stall dominates Flush and redirect.
REQ-026 Stall=0 with redirect SHALL load PC with target and load IF/ID with bubble (no delay slot): ID_Valid=0, ID_Inst=0, ID_PC4=0.
REQ-027 Stall=0, Flush=1, no redirect: PC SHALL advance PC+4 and IF/ID SHALL load bubble.
REQ-028 Stall=0, Flush=1 with redirect: redirect target SHALL load PC; IF/ID bubble.
REQ-029 Stall=0, no Flush, no redirect: ID_Inst<=Imem_Data, ID_PC4<=PC+4, ID_Valid<=1, Fetch_Count<=Fetch_Count+1 (wraps at 2^32).
REQ-030 Fetch-to-ID latency SHALL be exactly one clock.
REQ-031 Bubble loads SHALL NOT increment Fetch_Count.

Reset
REQ-032 Reset=0 SHALL immediately, independent of Clk, set PC=RESET_PC, ID_Inst=0, ID_PC4=0, ID_Valid=0, Fetch_Count=0.
REQ-033 Reset asserted mid-operation SHALL discard pending redirect/stall; first posedge after release SHALL load IF/ID from address RESET_PC.
REQ-034 All inputs SHALL be ignored while Reset=0.

Verification
REQ-035 Sequential: reset release, 3 clocks, Imem returns addr-dependent words -> Imem_Addr 0,4,8,C; ID_PC4 4,8,C; Fetch_Count=3.
REQ-036 Branch: ID_PC4=32'h10, Br_Offset=16'hFFFE, Br_Taken=1 -> next PC=32'h08, ID_Valid=0, Fetch_Count unchanged.
REQ-037 Priority: ID_PC4=32'h4000_0010, Jr_Taken=1 Jr_Addr=32'h123, Jmp_Taken=1 Jmp_Index=26'h10 -> PC=32'h120; repeat with Jr_Taken=0 -> PC=32'h4000_0040.
REQ-038 Stall with Br_Taken=1 for 2 clocks -> PC, IF/ID, Fetch_Count frozen; Stall=0 next clock -> branch taken.
REQ-039 Wrap: PC=32'hFFFF_FFFC, no redirect -> PC=0, ID_PC4=0, ID_Valid=1.
REQ-040 Reset pulse asynchronous between edges with PC=32'h40 -> PC=RESET_PC and ID_Valid=0 before next posedge.
